div_arbiter: RTL and testbench
==============================

# div_arbiter

Round-robin scheduler that shares one pipelined N-bit divider among `NREQ` requesters. It accepts one divide request per cycle through per-requester valid/ready handshakes and registers the operands onto the divider inputs. A tag pipeline matched to the divider latency steers each quotient/remainder back to its originating requester. The block sits between the requester ports and the divider instance, which it does not contain.

## Interface
- `DIVIDEND`, 4: dividend and quotient width in bits.
- `DIVISOR`, 2: divisor and remainder width in bits.
- `NREQ`, 4: number of requesters (2..8).
- `LATENCY`, 4: divider latency in cycles from operands presented to result valid (>=1).

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `en` in 1: arbitration enable; when 0, no new grants.
- `req_valid` in NREQ: per-requester request valid.
- `req_ready` out NREQ: per-requester accept (one-hot or zero).
- `req_dividend` in NREQ*DIVIDEND: packed; requester i at [i*DIVIDEND +: DIVIDEND].
- `req_divisor` in NREQ*DIVISOR: packed; requester i at [i*DIVISOR +: DIVISOR].
- `div_dividend` out DIVIDEND: registered operand to divider.
- `div_divisor` out DIVISOR: registered operand to divider.
- `div_quotient` in DIVIDEND: divider result.
- `div_remainder` in DIVISOR: divider result.
- `rsp_valid` out NREQ: one-hot response strobe, one cycle per accepted request.
- `rsp_quotient` out DIVIDEND: shared response data.
- `rsp_remainder` out DIVISOR: shared response data.
- `rsp_divzero` out 1: the response's divisor was 0.
- `inflight` out $clog2(LATENCY+2): accepted requests not yet responded.

## Operation
- Grant logic is combinational: `req_ready[i]`=1 for exactly the first requester with `req_valid` set, searching from `last+1` upward and wrapping modulo NREQ. It is 0 for all requesters when `en`=0 or when none is valid.
- A request is accepted on the rising edge where `req_valid[i] & req_ready[i]`.
- `last` updates to i only on an accept. Reset value is NREQ-1, so requester 0 has first priority.
- Requesters must hold valid and operands stable until accepted. The block never drops a valid request.
- On accept, the operands register into `div_dividend`/`div_divisor` and remain there until the next accept. When idle, the operands hold their previous values.
- The tag pipeline has LATENCY+1 stages. Each stage holds {valid, requester index, divzero}. Stage 0 loads on accept and loads a bubble (valid=0) otherwise. The pipeline shifts every cycle with no stall.
- Response stage:
  - The final tag and `div_quotient`/`div_remainder` are registered into the rsp outputs.
  - `rsp_valid` is the one-hot decode of the tag index when the tag is valid, and 0 otherwise.
  - When the divzero tag is set, `rsp_quotient` is all ones, `rsp_remainder`=0 and `rsp_divzero`=1. Divider outputs are ignored for that entry.
  - When no response is valid, `rsp_quotient`/`rsp_remainder` hold their previous values.
- Responses have no backpressure. Requesters must accept a response in the cycle it is strobed.
- Responses return in acceptance order, at most one per cycle.
- `inflight`:
  - +1 on accept, −1 on response strobe.
  - Unchanged when both happen in the same cycle.
  - Maximum value is LATENCY+1.

## Timing
- Reset (asynchronous, `reset_n`=0): all tag valids=0, `rsp_valid`=0, `rsp_quotient`=0, `rsp_remainder`=0, `rsp_divzero`=0, `div_dividend`=0, `div_divisor`=0, `inflight`=0, `last`=NREQ-1.
- Reset mid-operation discards all in-flight requests. No responses for them appear after reset release.
- `req_ready` is combinational from `req_valid`, `en` and `last`.
- Latency: a request accepted at edge k presents operands to the divider in cycle k..k+1. `rsp_valid` is high for one cycle after edge k+LATENCY+1. With LATENCY=4, that is after edge k+5.
- Throughput is one request per cycle, sustained, from any mix of requesters, including the same requester back-to-back.
- If `en` falls while a request is valid, no accept occurs in that cycle. In-flight entries still drain.

## Test plan
- Single request, requester 1, 13/3, LATENCY=4, accepted at edge k -> after edge k+5: `rsp_valid`=0010, q=4, r=1, divzero=0, for one cycle. `inflight` goes 1→0.
- All four requesters valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive edges. Responses appear in the same order with no gaps. `inflight` saturates at 5.
- Requester 2 alone issues 15/1, 6/2, 7/3 on consecutive cycles -> `req_ready[2]`=1 each cycle. Responses (15,0), (3,0), (2,1) arrive on three consecutive cycles.
- 9/0 from requester 3 -> `rsp_valid`=1000, `rsp_divzero`=1, q=4'hF, r=0. The preceding and following nonzero-divisor responses are correct.
- Accept three requests, then pull `reset_n` low before any response -> all outputs go to reset values immediately. No `rsp_valid` appears after release. `inflight`=0.
- `en`=0 with requesters 0 and 2 valid for 3 cycles -> `req_ready`=0 throughout. `en`=1 with `last`=0 -> requester 2 is granted first, then 0.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Requester, divider and response signals shared between div_arbiter and its neighbours.
// slave = the arbiter's view; master = the requesters/divider side.
interface div_arbiter_if #(
  parameter int DIVIDEND = 4,
  parameter int DIVISOR  = 2,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 4
);
  localparam int CNT_W = $clog2(LATENCY + 2);

  logic                         en;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ*DIVIDEND-1:0]     req_dividend;
  logic [NREQ*DIVISOR-1:0]      req_divisor;
  logic [DIVIDEND-1:0]          div_dividend;
  logic [DIVISOR-1:0]           div_divisor;
  logic [DIVIDEND-1:0]          div_quotient;
  logic [DIVISOR-1:0]           div_remainder;
  logic [NREQ-1:0]              rsp_valid;
  logic [DIVIDEND-1:0]          rsp_quotient;
  logic [DIVISOR-1:0]           rsp_remainder;
  logic                         rsp_divzero;
  logic [CNT_W-1:0]             inflight;

  modport slave (
    input  en, req_valid, req_dividend, req_divisor, div_quotient, div_remainder,
    output req_ready, div_dividend, div_divisor,
           rsp_valid, rsp_quotient, rsp_remainder, rsp_divzero, inflight
  );

  modport master (
    output en, req_valid, req_dividend, req_divisor, div_quotient, div_remainder,
    input  req_ready, div_dividend, div_divisor,
           rsp_valid, rsp_quotient, rsp_remainder, rsp_divzero, inflight
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin front end for one shared pipelined divider: grants one request per cycle,
// registers its operands to the divider and steers each result back through a tag pipeline.
module div_arbiter #(
  parameter int DIVIDEND = 4,
  parameter int DIVISOR  = 2,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  div_arbiter_if.slave  bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 2);

  function automatic logic [NREQ-1:0] decode(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) v[i] = (idx == IDX_W'(i));
    return v;
  endfunction

  // A zero divisor forces the saturated all-ones quotient and a zero remainder.
  function automatic logic [DIVIDEND-1:0] sat_quotient(input logic dz, input logic [DIVIDEND-1:0] q);
    return dz ? {DIVIDEND{1'b1}} : q;
  endfunction

  function automatic logic [DIVISOR-1:0] sat_remainder(input logic dz, input logic [DIVISOR-1:0] r);
    return dz ? {DIVISOR{1'b0}} : r;
  endfunction

  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic                accept;
  logic [DIVIDEND-1:0] acc_dividend;
  logic [DIVISOR-1:0]  acc_divisor;

  // Search starts just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NREQ);
      if (!grant_any && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept        = grant_any & bus.en;
  assign bus.req_ready = accept ? decode(grant_idx) : '0;
  assign acc_dividend  = bus.req_dividend[int'(grant_idx)*DIVIDEND +: DIVIDEND];
  assign acc_divisor   = bus.req_divisor[int'(grant_idx)*DIVISOR +: DIVISOR];

  // ---- stage p0: operands to divider, tag pipeline entry ----
  logic [DIVIDEND-1:0] opnd_dividend_p0;
  logic [DIVISOR-1:0]  opnd_divisor_p0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last             <= IDX_W'(NREQ - 1);
      opnd_dividend_p0 <= '0;
      opnd_divisor_p0  <= '0;
    end else if (accept) begin
      last             <= grant_idx;
      opnd_dividend_p0 <= acc_dividend;
      opnd_divisor_p0  <= acc_divisor;
    end
  end

  assign bus.div_dividend = opnd_dividend_p0;
  assign bus.div_divisor  = opnd_divisor_p0;

  logic             tag_vld_p [0:LATENCY];
  logic [IDX_W-1:0] tag_idx_p [0:LATENCY];
  logic             tag_dz_p  [0:LATENCY];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s <= LATENCY; s++) tag_vld_p[s] <= 1'b0;
    end else begin
      tag_vld_p[0] <= accept;
      for (int s = 1; s <= LATENCY; s++) tag_vld_p[s] <= tag_vld_p[s-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_idx_p[0] <= grant_idx;
    tag_dz_p[0]  <= (acc_divisor == '0);
    for (int s = 1; s <= LATENCY; s++) begin
      tag_idx_p[s] <= tag_idx_p[s-1];
      tag_dz_p[s]  <= tag_dz_p[s-1];
    end
  end

  // ---- stage pn: final tag meets divider result ----
  logic [NREQ-1:0]     rsp_valid_pn;
  logic [DIVIDEND-1:0] rsp_quotient_pn;
  logic [DIVISOR-1:0]  rsp_remainder_pn;
  logic                rsp_divzero_pn;
  logic [CNT_W-1:0]    inflight_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_pn     <= '0;
      rsp_quotient_pn  <= '0;
      rsp_remainder_pn <= '0;
      rsp_divzero_pn   <= 1'b0;
    end else if (tag_vld_p[LATENCY]) begin
      rsp_valid_pn     <= decode(tag_idx_p[LATENCY]);
      rsp_quotient_pn  <= sat_quotient(tag_dz_p[LATENCY], bus.div_quotient);
      rsp_remainder_pn <= sat_remainder(tag_dz_p[LATENCY], bus.div_remainder);
      rsp_divzero_pn   <= tag_dz_p[LATENCY];
    end else begin
      rsp_valid_pn     <= '0;
      rsp_divzero_pn   <= 1'b0;
    end
  end

  // Decrement on the edge that launches the strobe, so the count peaks at LATENCY+1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_cnt <= '0;
    end else begin
      case ({accept, tag_vld_p[LATENCY]})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  assign bus.rsp_valid     = rsp_valid_pn;
  assign bus.rsp_quotient  = rsp_quotient_pn;
  assign bus.rsp_remainder = rsp_remainder_pn;
  assign bus.rsp_divzero   = rsp_divzero_pn;
  assign bus.inflight      = inflight_cnt;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural LATENCY-cycle divider attached.
module tb_div_arbiter;
  localparam int DIVIDEND = 4;
  localparam int DIVISOR  = 2;
  localparam int NREQ     = 4;
  localparam int LATENCY  = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  div_arbiter_if #(.DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .NREQ(NREQ), .LATENCY(LATENCY)) bus();

  div_arbiter #(.DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Divider model: operands seen after edge k give a result after edge k+LATENCY.
  logic [3:0] pd [0:LATENCY-1];
  logic [1:0] pv [0:LATENCY-1];
  always @(posedge clock) begin
    pd[0] <= bus.div_dividend;
    pv[0] <= bus.div_divisor;
    for (int i = 1; i < LATENCY; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
  end
  assign bus.div_quotient  = (pv[LATENCY-1] == 2'd0) ? 4'h5 : pd[LATENCY-1] / {2'b00, pv[LATENCY-1]};
  assign bus.div_remainder = (pv[LATENCY-1] == 2'd0) ? 2'b11 : 2'(pd[LATENCY-1] % {2'b00, pv[LATENCY-1]});

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic set_req(input int i, input logic [3:0] a, input logic [1:0] b);
    bus.req_dividend[i*DIVIDEND +: DIVIDEND] = a;
    bus.req_divisor[i*DIVISOR +: DIVISOR]    = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.en        = 1'b1;
    reset_n       = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    int         req;
    logic [3:0] a;
    logic [1:0] b;
    logic [3:0] q;
    logic [1:0] r;
    logic       dz;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  logic [3:0] exp_q3 [4];
  logic [1:0] exp_r3 [4];
  int j, acc_n, rsp_n, seen;

  initial begin
    vt[0] = '{2, 4'd15, 2'd1, 4'd15, 2'd0, 1'b0};
    vt[1] = '{2, 4'd6,  2'd2, 4'd3,  2'd0, 1'b0};
    vt[2] = '{2, 4'd7,  2'd3, 4'd2,  2'd1, 1'b0};
    vt[3] = '{1, 4'd5,  2'd2, 4'd2,  2'd1, 1'b0};
    vt[4] = '{3, 4'd9,  2'd0, 4'hF,  2'd0, 1'b1};
    vt[5] = '{0, 4'd11, 2'd3, 4'd3,  2'd2, 1'b0};
    vt[6] = '{3, 4'd8,  2'd3, 4'd2,  2'd2, 1'b0};
    vt[7] = '{1, 4'd14, 2'd3, 4'd4,  2'd2, 1'b0};

    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    do_reset();

    // Reset state
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_q", bus.rsp_quotient, 0);
    check("rst_rsp_r", bus.rsp_remainder, 0);
    check("rst_rsp_dz", bus.rsp_divzero, 0);
    check("rst_div_dividend", bus.div_dividend, 0);
    check("rst_div_divisor", bus.div_divisor, 0);
    check("rst_inflight", bus.inflight, 0);
    bus.req_valid = 4'b1111;
    #1 check("rst_first_grant", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0000;
    #1 check("idle_no_grant", bus.req_ready, 0);

    // Single request: requester 1, 13/3
    set_req(1, 4'd13, 2'd3);
    bus.req_valid = 4'b0010;
    #1 check("single_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b0000;
    check("single_div_dividend", bus.div_dividend, 13);
    check("single_div_divisor", bus.div_divisor, 3);
    check("single_inflight1", bus.inflight, 1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c < 5) check("single_early", bus.rsp_valid, 0);
    end
    check("single_rsp_valid", bus.rsp_valid, 4'b0010);
    check("single_q", bus.rsp_quotient, 4);
    check("single_r", bus.rsp_remainder, 1);
    check("single_dz", bus.rsp_divzero, 0);
    check("single_inflight0", bus.inflight, 0);
    tick();
    check("single_one_cycle", bus.rsp_valid, 0);

    // Table: back-to-back stream, one requester valid per cycle
    for (int i = 0; i < NV + LATENCY + 1; i++) begin
      if (i < NV) begin
        set_req(vt[i].req, vt[i].a, vt[i].b);
        bus.req_valid = oh(vt[i].req);
        #1 check("tbl_ready", bus.req_ready, oh(vt[i].req));
      end else begin
        bus.req_valid = 4'b0000;
      end
      tick();
      j = i - (LATENCY + 1);
      if (j >= 0) begin
        check("tbl_rsp_valid", bus.rsp_valid, oh(vt[j].req));
        check("tbl_q", bus.rsp_quotient, vt[j].q);
        check("tbl_r", bus.rsp_remainder, vt[j].r);
        check("tbl_dz", bus.rsp_divzero, vt[j].dz);
      end else begin
        check("tbl_no_rsp", bus.rsp_valid, 0);
      end
    end
    tick();
    check("hold_rsp_valid", bus.rsp_valid, 0);
    check("hold_q", bus.rsp_quotient, 4);
    check("hold_r", bus.rsp_remainder, 2);
    check("tbl_inflight", bus.inflight, 0);

    // All four valid continuously from reset
    do_reset();
    exp_q3[0] = 4'd6; exp_r3[0] = 2'd0; set_req(0, 4'd12, 2'd2);
    exp_q3[1] = 4'd4; exp_r3[1] = 2'd1; set_req(1, 4'd13, 2'd3);
    exp_q3[2] = 4'd3; exp_r3[2] = 2'd1; set_req(2, 4'd7,  2'd2);
    exp_q3[3] = 4'd3; exp_r3[3] = 2'd1; set_req(3, 4'd10, 2'd3);
    for (int i = 0; i < 11; i++) begin
      if (i < 6) begin
        bus.req_valid = 4'b1111;
        #1 check("rr_grant", bus.req_ready, oh(i % 4));
      end else begin
        bus.req_valid = 4'b0000;
      end
      tick();
      j = i - 5;
      if (j >= 0 && j < 6) begin
        check("rr_rsp_valid", bus.rsp_valid, oh(j % 4));
        check("rr_q", bus.rsp_quotient, exp_q3[j % 4]);
        check("rr_r", bus.rsp_remainder, exp_r3[j % 4]);
      end else begin
        check("rr_no_rsp", bus.rsp_valid, 0);
      end
      acc_n = (i + 1 < 6) ? i + 1 : 6;
      rsp_n = (i - 4 < 0) ? 0 : ((i - 4 > 6) ? 6 : i - 4);
      check("rr_inflight", bus.inflight, acc_n - rsp_n);
    end

    // Reset while three requests are in flight
    set_req(0, 4'd9, 2'd1);
    set_req(1, 4'd8, 2'd2);
    set_req(2, 4'd6, 2'd3);
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    bus.req_valid = 4'b0000;
    check("mid_inflight3", bus.inflight, 3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_q", bus.rsp_quotient, 0);
    check("mid_rst_div_dividend", bus.div_dividend, 0);
    check("mid_rst_div_divisor", bus.div_divisor, 0);
    check("mid_rst_inflight", bus.inflight, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid != 4'b0000) seen++;
    end
    check("mid_no_stale_rsp", seen, 0);
    check("mid_inflight_after", bus.inflight, 0);
    bus.req_valid = 4'b1111;
    #1 check("mid_last_reset", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0000;

    // en=0 blocks grants; re-enable with last=0
    set_req(0, 4'd12, 2'd2);
    bus.req_valid = 4'b0001;
    tick();
    set_req(2, 4'd7, 2'd2);
    bus.en        = 1'b0;
    bus.req_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1 check("en0_ready", bus.req_ready, 0);
      check("en0_inflight", bus.inflight, 1);
      tick();
    end
    bus.en = 1'b1;
    #1 check("en1_first", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b0001;
    #1 check("en1_second", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    repeat (8) tick();
    check("en_drain_inflight", bus.inflight, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
